// File: rtl/sort_net_pipe.sv
// sort_net_pipe: fully pipelined Batcher odd-even merge sorter, one register stage per layer.
// Optional macro SORT_TAG_EN carries original-index tags, adds out_tag and breaks key ties by index.

module sort_net_pipe #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_desc,
  input  logic [(WIDTH<<LOG2N)-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef SORT_TAG_EN
  output logic [(LOG2N<<LOG2N)-1:0] out_tag,
`endif
  output logic [(WIDTH<<LOG2N)-1:0] out_data
);

  localparam int N = 1 << LOG2N;
  localparam int S = LOG2N * (LOG2N + 1) / 2;

  // Layers enumerate the classic (p, k) loop nest of the odd-even merge sort.
  function automatic int layerP(input int layer);
    int cnt;
    int res;
    cnt = 0;
    res = 1;
    for (int p = 1; p < N; p = p * 2)
      for (int k = p; k >= 1; k = k / 2) begin
        if (cnt == layer) res = p;
        cnt++;
      end
    return res;
  endfunction

  function automatic int layerK(input int layer);
    int cnt;
    int res;
    cnt = 0;
    res = 1;
    for (int p = 1; p < N; p = p * 2)
      for (int k = p; k >= 1; k = k / 2) begin
        if (cnt == layer) res = k;
        cnt++;
      end
    return res;
  endfunction

  function automatic bit isLow(input int layer, input int a);
    int p;
    int k;
    int off;
    p   = layerP(layer);
    k   = layerK(layer);
    off = k % p;
    return (a >= off) && (((a - off) % (2 * k)) < k) && (a + k < N) &&
           ((a / (2 * p)) == ((a + k) / (2 * p)));
  endfunction

  logic [WIDTH-1:0] keyReg  [0:S][0:N-1];
  logic [WIDTH-1:0] keyNext [0:S-1][0:N-1];
  logic             validReg[0:S];
  logic             descReg [0:S];
`ifdef SORT_TAG_EN
  logic [LOG2N-1:0] tagReg  [0:S][0:N-1];
  logic [LOG2N-1:0] tagNext [0:S-1][0:N-1];
`endif
  logic             advance;

  assign advance   = ~validReg[S] | out_ready;
  assign in_ready  = advance;
  assign out_valid = validReg[S];

  // Each low slot owns its comparator and drives both of its outputs; untouched slots pass through.
  for (genvar s = 0; s < S; s++) begin : gLayer
    localparam int K = layerK(s);
    for (genvar a = 0; a < N; a++) begin : gSlot
      if (isLow(s, a)) begin : gLo
        logic keyGt;
        logic keyLt;
        logic tieSwap;
        logic swap;
        assign keyGt = keyReg[s][a] > keyReg[s][a+K];
        assign keyLt = keyReg[s][a] < keyReg[s][a+K];
`ifdef SORT_TAG_EN
        assign tieSwap = (keyReg[s][a] == keyReg[s][a+K]) && (tagReg[s][a] > tagReg[s][a+K]);
        assign tagNext[s][a]   = swap ? tagReg[s][a+K] : tagReg[s][a];
        assign tagNext[s][a+K] = swap ? tagReg[s][a]   : tagReg[s][a+K];
`else
        assign tieSwap = 1'b0;
`endif
        assign swap = (descReg[s] ? keyLt : keyGt) | tieSwap;
        assign keyNext[s][a]   = swap ? keyReg[s][a+K] : keyReg[s][a];
        assign keyNext[s][a+K] = swap ? keyReg[s][a]   : keyReg[s][a+K];
      end else if (!(a >= K && isLow(s, a - K))) begin : gPass
        assign keyNext[s][a] = keyReg[s][a];
`ifdef SORT_TAG_EN
        assign tagNext[s][a] = tagReg[s][a];
`endif
      end
    end
  end

  // Global stall: the whole pipe either shifts one stage or holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= S; s++) begin
        validReg[s] <= 1'b0;
        descReg[s]  <= 1'b0;
        for (int a = 0; a < N; a++) begin
          keyReg[s][a] <= '0;
`ifdef SORT_TAG_EN
          tagReg[s][a] <= '0;
`endif
        end
      end
    end else if (advance) begin
      validReg[0] <= in_valid;
      descReg[0]  <= in_desc;
      for (int a = 0; a < N; a++) begin
        keyReg[0][a] <= in_data[a*WIDTH +: WIDTH];
`ifdef SORT_TAG_EN
        tagReg[0][a] <= LOG2N'(a);
`endif
      end
      for (int s = 1; s <= S; s++) begin
        validReg[s] <= validReg[s-1];
        descReg[s]  <= descReg[s-1];
        for (int a = 0; a < N; a++) begin
          keyReg[s][a] <= keyNext[s-1][a];
`ifdef SORT_TAG_EN
          tagReg[s][a] <= tagNext[s-1][a];
`endif
        end
      end
    end
  end

  for (genvar a = 0; a < N; a++) begin : gOut
    assign out_data[a*WIDTH +: WIDTH] = keyReg[S][a];
`ifdef SORT_TAG_EN
    assign out_tag[a*LOG2N +: LOG2N] = tagReg[S][a];
`endif
  end

endmodule

// File: tb/tb_sort_net_pipe.sv
// tb_sort_net_pipe: directed self-checking bench for sort_net_pipe at N=8, WIDTH=16.
// Tag checks are compiled in only when SORT_TAG_EN is defined.

module tb_sort_net_pipe;

  localparam int WIDTH = 16;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int S     = 6;
  localparam int LAT   = S + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_desc;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef SORT_TAG_EN
  logic [23:0]  out_tag;
`endif

  int vecCount = 0;
  int missCount = 0;

  sort_net_pipe #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SORT_TAG_EN
    .out_tag   (out_tag),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] pack8(input int k0, input int k1, input int k2, input int k3,
                                         input int k4, input int k5, input int k6, input int k7);
    return {16'(k7), 16'(k6), 16'(k5), 16'(k4), 16'(k3), 16'(k2), 16'(k1), 16'(k0)};
  endfunction

  function automatic logic [23:0] tags8(input int t0, input int t1, input int t2, input int t3,
                                        input int t4, input int t5, input int t6, input int t7);
    return {3'(t7), 3'(t6), 3'(t5), 3'(t4), 3'(t3), 3'(t2), 3'(t1), 3'(t0)};
  endfunction

  // Stable insertion sort: equal keys keep lowest original index first in both directions.
  function automatic void refSort(input logic [127:0] data, input logic desc,
                                  output logic [127:0] keysOut, output logic [23:0] tagsOut);
    logic [15:0] k[8];
    int          t[8];
    logic [15:0] kt;
    int          tt;
    for (int i = 0; i < 8; i++) begin
      k[i] = data[i*16 +: 16];
      t[i] = i;
    end
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0; j--)
        if (desc ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
          kt = k[j-1]; k[j-1] = k[j]; k[j] = kt;
          tt = t[j-1]; t[j-1] = t[j]; t[j] = tt;
        end
    for (int i = 0; i < 8; i++) begin
      keysOut[i*16 +: 16] = k[i];
      tagsOut[i*3 +: 3]   = 3'(t[i]);
    end
  endfunction

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic sendAndWait(input logic desc, input logic [127:0] data, output int edges);
    in_valid = 1'b1;
    in_desc  = desc;
    in_data  = data;
    stepEdge();
    edges    = 1;
    in_valid = 1'b0;
    in_desc  = 1'b0;
    in_data  = '0;
    while (!out_valid && edges < 30) begin
      stepEdge();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_desc = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecCount++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL reset_valid: got %b, want 0", out_valid); missCount++;
    end
    vecCount++;
    if (out_data !== 128'h0) begin
      $display("[TB] FAIL reset_data: got %h, want 0", out_data); missCount++;
    end
`ifdef SORT_TAG_EN
    vecCount++;
    if (out_tag !== 24'h0) begin
      $display("[TB] FAIL reset_tag: got %h, want 0", out_tag); missCount++;
    end
`endif
    rst_n = 1'b1;
    stepEdge();
    vecCount++;
    if (in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready); missCount++;
    end
    vecCount++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL reset_release_valid: got %b, want 0", out_valid); missCount++;
    end
  endtask

  task automatic test_ascending();
    int edges;
    sendAndWait(1'b0, pack8(7, 3, 9, 1, 8, 2, 6, 4), edges);
    vecCount++;
    if (edges !== LAT) begin
      $display("[TB] FAIL asc_latency: got %0d edges, want %0d", edges, LAT); missCount++;
    end
    vecCount++;
    if (out_data !== pack8(1, 2, 3, 4, 6, 7, 8, 9)) begin
      $display("[TB] FAIL asc_data: got %h, want %h", out_data, pack8(1, 2, 3, 4, 6, 7, 8, 9)); missCount++;
    end
`ifdef SORT_TAG_EN
    vecCount++;
    if (out_tag !== tags8(3, 5, 1, 7, 6, 0, 4, 2)) begin
      $display("[TB] FAIL asc_tag: got %h, want %h", out_tag, tags8(3, 5, 1, 7, 6, 0, 4, 2)); missCount++;
    end
`endif
    stepEdge();
    vecCount++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL asc_bubble: got %b, want 0", out_valid); missCount++;
    end
  endtask

  task automatic test_descending();
    int edges;
    sendAndWait(1'b1, pack8(7, 3, 9, 1, 8, 2, 6, 4), edges);
    vecCount++;
    if (edges !== LAT) begin
      $display("[TB] FAIL desc_latency: got %0d edges, want %0d", edges, LAT); missCount++;
    end
    vecCount++;
    if (out_data !== pack8(9, 8, 7, 6, 4, 3, 2, 1)) begin
      $display("[TB] FAIL desc_data: got %h, want %h", out_data, pack8(9, 8, 7, 6, 4, 3, 2, 1)); missCount++;
    end
`ifdef SORT_TAG_EN
    vecCount++;
    if (out_tag !== tags8(2, 4, 0, 6, 7, 1, 5, 3)) begin
      $display("[TB] FAIL desc_tag: got %h, want %h", out_tag, tags8(2, 4, 0, 6, 7, 1, 5, 3)); missCount++;
    end
`endif
    stepEdge();
  endtask

  task automatic test_equal_keys();
    int edges;
    for (int d = 0; d < 2; d++) begin
      sendAndWait(1'(d), pack8(5, 5, 5, 5, 5, 5, 5, 5), edges);
      vecCount++;
      if (out_data !== pack8(5, 5, 5, 5, 5, 5, 5, 5) || edges !== LAT) begin
        $display("[TB] FAIL equal_data desc=%0d: got %h after %0d edges, want all 0005 after %0d",
                 d, out_data, edges, LAT); missCount++;
      end
`ifdef SORT_TAG_EN
      vecCount++;
      if (out_tag !== tags8(0, 1, 2, 3, 4, 5, 6, 7)) begin
        $display("[TB] FAIL equal_tag desc=%0d: got %h, want %h", d, out_tag, tags8(0, 1, 2, 3, 4, 5, 6, 7));
        missCount++;
      end
`endif
      stepEdge();
    end
  endtask

  task automatic test_extremes();
    int edges;
    logic [127:0] keys;
    keys = pack8(16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h1234, 16'h0000);
    sendAndWait(1'b0, keys, edges);
    vecCount++;
    if (out_data !== pack8(16'h0000, 16'h0000, 16'h0001, 16'h1234, 16'h7FFF, 16'h8000, 16'hFFFE, 16'hFFFF)) begin
      $display("[TB] FAIL extreme_asc: got %h", out_data); missCount++;
    end
`ifdef SORT_TAG_EN
    vecCount++;
    if (out_tag !== tags8(2, 7, 4, 6, 3, 0, 5, 1)) begin
      $display("[TB] FAIL extreme_asc_tag: got %h, want %h", out_tag, tags8(2, 7, 4, 6, 3, 0, 5, 1)); missCount++;
    end
`endif
    stepEdge();
    sendAndWait(1'b1, keys, edges);
    vecCount++;
    if (out_data !== pack8(16'hFFFF, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h1234, 16'h0001, 16'h0000, 16'h0000)) begin
      $display("[TB] FAIL extreme_desc: got %h", out_data); missCount++;
    end
`ifdef SORT_TAG_EN
    vecCount++;
    if (out_tag !== tags8(1, 5, 0, 3, 6, 4, 2, 7)) begin
      $display("[TB] FAIL extreme_desc_tag: got %h, want %h", out_tag, tags8(1, 5, 0, 3, 6, 4, 2, 7)); missCount++;
    end
`endif
    stepEdge();
  endtask

  task automatic test_back_to_back();
    logic [127:0] items[20];
    logic         descs[20];
    logic [127:0] expData[$];
    logic [23:0]  expTag[$];
    logic [127:0] eKeys;
    logic [23:0]  eTags;
    int nextIn, got, firstOut, lastOut, readyLow;
    logic acc;
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 8; j++)
        items[i][j*16 +: 16] = 16'($urandom_range(0, (i % 2 == 0) ? 3 : 65535));
      descs[i] = 1'($urandom_range(0, 1));
    end
    nextIn = 0; got = 0; firstOut = -1; lastOut = -1; readyLow = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 + LAT + 5; cyc++) begin
      in_valid = (nextIn < 20);
      in_desc  = (nextIn < 20) ? descs[nextIn] : 1'b0;
      in_data  = (nextIn < 20) ? items[nextIn] : '0;
      #1;
      if (out_valid) begin
        vecCount++;
        if (expData.size() == 0) begin
          $display("[TB] FAIL b2b_extra: got %h, want no output", out_data); missCount++;
        end else begin
          eKeys = expData.pop_front();
          eTags = expTag.pop_front();
          if (out_data !== eKeys) begin
            $display("[TB] FAIL b2b_data #%0d: got %h, want %h", got, out_data, eKeys); missCount++;
          end
`ifdef SORT_TAG_EN
          vecCount++;
          if (out_tag !== eTags) begin
            $display("[TB] FAIL b2b_tag #%0d: got %h, want %h", got, out_tag, eTags); missCount++;
          end
`endif
        end
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
        got++;
      end
      if (in_valid && !in_ready) readyLow++;
      acc = in_valid && in_ready;
      stepEdge();
      if (acc) begin
        refSort(items[nextIn], descs[nextIn], eKeys, eTags);
        expData.push_back(eKeys);
        expTag.push_back(eTags);
        nextIn++;
      end
    end
    in_valid = 1'b0;
    vecCount++;
    if (got !== 20) begin
      $display("[TB] FAIL b2b_count: got %0d outputs, want 20", got); missCount++;
    end
    vecCount++;
    if (lastOut - firstOut !== 19) begin
      $display("[TB] FAIL b2b_consecutive: got span %0d, want 19", lastOut - firstOut); missCount++;
    end
    vecCount++;
    if (readyLow !== 0) begin
      $display("[TB] FAIL b2b_in_ready: got %0d low cycles, want 0", readyLow); missCount++;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] items[12];
    logic [127:0] expData[$];
    logic [127:0] eKeys;
    logic [23:0]  eTags;
    logic [127:0] held;
    int nextIn, got;
    logic acc, stall;
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 8; j++)
        items[i][j*16 +: 16] = 16'(i * 97 + (7 - j) * 13 + ((j * 5) % 3) * 1000);
    nextIn = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      stall     = (cyc >= 10 && cyc < 15);
      out_ready = !stall;
      in_valid  = (nextIn < 12);
      in_desc   = 1'b0;
      in_data   = (nextIn < 12) ? items[nextIn] : '0;
      #1;
      if (stall) begin
        vecCount++;
        if (in_ready !== 1'b0) begin
          $display("[TB] FAIL bp_in_ready cyc %0d: got %b, want 0", cyc, in_ready); missCount++;
        end
        if (cyc == 10) held = out_data;
        else begin
          vecCount++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            $display("[TB] FAIL bp_hold cyc %0d: got %b/%h, want 1/%h", cyc, out_valid, out_data, held);
            missCount++;
          end
        end
      end
      if (out_valid && out_ready) begin
        vecCount++;
        if (expData.size() == 0) begin
          $display("[TB] FAIL bp_extra: got %h, want no output", out_data); missCount++;
        end else begin
          eKeys = expData.pop_front();
          if (out_data !== eKeys) begin
            $display("[TB] FAIL bp_data #%0d: got %h, want %h", got, out_data, eKeys); missCount++;
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      stepEdge();
      if (acc) begin
        refSort(items[nextIn], 1'b0, eKeys, eTags);
        expData.push_back(eKeys);
        nextIn++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vecCount++;
    if (got !== 12) begin
      $display("[TB] FAIL bp_count: got %0d outputs, want 12", got); missCount++;
    end
  endtask

  task automatic test_mid_reset();
    int edges, stale;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_desc  = 1'b0;
      in_data  = pack8(i + 1, 40, 30, 20, 10, 9, 8, 7);
      stepEdge();
    end
    in_valid = 1'b0;
    in_data  = '0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      stepEdge();
      edges++;
    end
    vecCount++;
    if (out_valid !== 1'b1) begin
      $display("[TB] FAIL midrst_fill: got out_valid %b, want 1", out_valid); missCount++;
    end
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      $display("[TB] FAIL midrst_clear: got %b/%h, want 0/0", out_valid, out_data); missCount++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < S + 3; c++) begin
      stepEdge();
      if (out_valid !== 1'b0) stale++;
    end
    vecCount++;
    if (stale !== 0) begin
      $display("[TB] FAIL midrst_stale: got %0d valid cycles, want 0", stale); missCount++;
    end
    sendAndWait(1'b1, pack8(5, 0, 3, 16'hAAAA, 1, 2, 7, 6), edges);
    vecCount++;
    if (edges !== LAT || out_data !== pack8(16'hAAAA, 7, 6, 5, 3, 2, 1, 0)) begin
      $display("[TB] FAIL midrst_next: got %h after %0d edges, want %h after %0d",
               out_data, edges, pack8(16'hAAAA, 7, 6, 5, 3, 2, 1, 0), LAT); missCount++;
    end
    stepEdge();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_desc = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_ascending();
    test_descending();
    test_equal_keys();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
